// File: rtl/m68k_bus_responder.sv
// 68000 bus target: decodes a 32-byte window, serves a 16-word register file,
// answers with DTACK after programmable wait states (BERR on writes to the ID word).
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for a fresh AS assertion that hits the window
// S_STROBE | address latched, waiting for UDS and/or LDS
// S_WAIT   | counting down wait states before answering
// S_ACK    | DTACK asserted (read data driven), held until AS negates
// S_ERR    | BERR asserted for an illegal write, held until AS negates
module m68k_bus_responder #(
    parameter logic [23:0] BASE_ADDR   = 24'hE80000,
    parameter int unsigned WAIT_CYCLES = 8,
    parameter logic [15:0] ID_VALUE    = 16'h5053
) (
    input  logic        PI_CLK,
    input  logic        M68K_RESET_n,
    input  logic [23:1] M68K_A,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    input  logic [15:0] M68K_D_IN,
    output logic [15:0] M68K_D_OUT,
    output logic        M68K_D_OE,
    output logic        M68K_DTACK_n,
    output logic        M68K_BERR_n,
    output logic [2:0]  M68K_IPL_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_ACK,
        S_ERR
    } state_t;

    localparam logic [3:0] ID_IDX  = 4'd14;
    localparam logic [3:0] IPL_IDX = 4'd15;

    state_t      r_state;
    logic [1:0]  r_as_sync;
    logic [1:0]  r_uds_sync;
    logic [1:0]  r_lds_sync;
    logic [1:0]  r_rw_sync;
    logic        r_armed;
    logic [3:0]  r_idx;
    logic        r_rw;
    logic        r_uds;
    logic        r_lds;
    logic [7:0]  r_cnt;
    logic [15:0] r_regs [16];
    logic [15:0] r_d_out;
    logic        r_d_oe;
    logic        r_dtack_n;
    logic        r_berr_n;
    logic [2:0]  r_ipl_n;

    logic        w_as_n;
    logic        w_uds_n;
    logic        w_lds_n;
    logic        w_rw;
    logic        w_hit;
    logic [15:0] w_rdata;

    assign w_as_n  = r_as_sync[1];
    assign w_uds_n = r_uds_sync[1];
    assign w_lds_n = r_lds_sync[1];
    assign w_rw    = r_rw_sync[1];
    assign w_hit   = (M68K_A[23:5] == BASE_ADDR[23:5]);
    assign w_rdata = (r_idx == ID_IDX) ? ID_VALUE : r_regs[r_idx];

    always_ff @(posedge PI_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            r_as_sync  <= 2'b11;
            r_uds_sync <= 2'b11;
            r_lds_sync <= 2'b11;
            r_rw_sync  <= 2'b11;
        end else begin
            r_as_sync  <= {r_as_sync[0], M68K_AS_n};
            r_uds_sync <= {r_uds_sync[0], M68K_UDS_n};
            r_lds_sync <= {r_lds_sync[0], M68K_LDS_n};
            r_rw_sync  <= {r_rw_sync[0], M68K_RW};
        end
    end

    always_ff @(posedge PI_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            r_state   <= S_IDLE;
            r_armed   <= 1'b0;
            r_idx     <= '0;
            r_rw      <= 1'b1;
            r_uds     <= 1'b0;
            r_lds     <= 1'b0;
            r_cnt     <= '0;
            r_d_out   <= '0;
            r_d_oe    <= 1'b0;
            r_dtack_n <= 1'b1;
            r_berr_n  <= 1'b1;
            r_ipl_n   <= 3'b111;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_ipl_n <= ~r_regs[IPL_IDX][2:0];
            case (r_state)
                S_IDLE: begin
                    // A cycle is only accepted once AS has been seen negated here.
                    if (w_as_n) begin
                        r_armed <= 1'b1;
                    end else if (r_armed && w_hit) begin
                        r_idx   <= M68K_A[4:1];
                        r_rw    <= w_rw;
                        r_armed <= 1'b0;
                        r_state <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (w_as_n) begin
                        r_state <= S_IDLE;
                    end else if (!w_uds_n || !w_lds_n) begin
                        r_uds   <= ~w_uds_n;
                        r_lds   <= ~w_lds_n;
                        r_cnt   <= 8'(WAIT_CYCLES);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_as_n) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 8'd0) begin
                        if (!r_rw && (r_idx == ID_IDX)) begin
                            r_berr_n <= 1'b0;
                            r_state  <= S_ERR;
                        end else begin
                            r_dtack_n <= 1'b0;
                            r_d_oe    <= r_rw;
                            r_state   <= S_ACK;
                            if (r_rw) begin
                                r_d_out <= w_rdata;
                            end else begin
                                if (r_uds) r_regs[r_idx][15:8] <= M68K_D_IN[15:8];
                                if (r_lds) r_regs[r_idx][7:0]  <= M68K_D_IN[7:0];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_ACK: begin
                    if (w_as_n) begin
                        r_dtack_n <= 1'b1;
                        r_d_oe    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (w_as_n) begin
                        r_berr_n <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign M68K_D_OUT   = r_d_out;
    assign M68K_D_OE    = r_d_oe;
    assign M68K_DTACK_n = r_dtack_n;
    assign M68K_BERR_n  = r_berr_n;
    assign M68K_IPL_n   = r_ipl_n;

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- 68000 bus target: the responder end of the asynchronous AS/UDS/LDS/DTACK handshake that the PiStorm bus master initiates.
- Decodes a 32-byte window, serves a 16-word register file and returns DTACK after programmable wait states, or BERR for illegal writes.
- Drives an IPL request from a register so the master's interrupt path can be exercised.
- Used as an on-board test target and bench partner for the bus master, clocked from the fast PI_CLK with all bus inputs synchronised.

Parameters:
- BASE_ADDR, 24'hE80000, window base; decode is A[23:5] == BASE_ADDR[23:5].
- WAIT_CYCLES, 8, PI_CLK cycles inserted between strobe qualification and DTACK; legal range 0..255.
- ID_VALUE, 16'h5053, read-only contents of word 14.

Ports:
- PI_CLK  in  1  single clock, rising edge.
- M68K_RESET_n  in  1  asynchronous, active-low reset.
- M68K_A  in  23  address bits A[23:1].
- M68K_AS_n  in  1  address strobe, asynchronous to PI_CLK.
- M68K_UDS_n  in  1  upper data strobe, D[15:8].
- M68K_LDS_n  in  1  lower data strobe, D[7:0].
- M68K_RW  in  1  1 = read, 0 = write.
- M68K_D_IN  in  16  write data from bus.
- M68K_D_OUT  out  16  read data to bus.
- M68K_D_OE  out  1  read data output enable.
- M68K_DTACK_n  out  1  data acknowledge.
- M68K_BERR_n  out  1  bus error.
- M68K_IPL_n  out  3  interrupt request, active low.

Behaviour:
- Reset: asynchronous, active-low.
  - DTACK_n = 1, BERR_n = 1, D_OE = 0, D_OUT = 0, IPL_n = 3'b111.
  - All registers = 0 except word 14; state = IDLE; wait counter = 0.
  - Reset asserted mid-cycle releases DTACK/BERR/OE immediately and discards any pending write.
- Synchronisers: AS_n, UDS_n, LDS_n and RW each pass through 2 flops. A, D_IN, RW are stable while AS is asserted; A and D_IN are sampled unsynchronised at the qualification points below.
- IDLE: when synced AS = 0 and address matches, latch A[4:1] as idx and RW as rw, then go to STROBE. On no match, stay in IDLE and never drive any output.
- STROBE: wait for synced UDS = 0 or LDS = 0, then latch both strobes, load counter = WAIT_CYCLES and go to WAIT. Synced AS = 1 at any point returns to IDLE with no effect.
- WAIT: decrement the counter each cycle. At 0, go to ACK, or to ERR if rw = 0 and idx = 14.
  - Read: D_OUT <= reg[idx] (full word regardless of strobes) on the ACK entry edge.
  - Write: commit on the ACK entry edge. UDS writes D_IN[15:8] to [15:8]; LDS writes D_IN[7:0] to [7:0].
  - AS negated during WAIT: return to IDLE with no write.
- ACK: DTACK_n = 0; D_OE = rw. Hold until synced AS = 1, then on the same edge set DTACK_n = 1, D_OE = 0 and go to IDLE.
- ERR: BERR_n = 0, no write, D_OE = 0. Release on synced AS = 1, as in ACK.
- Latency: with AS_n and a strobe falling together, DTACK_n goes low on the (WAIT_CYCLES + 4)th PI_CLK rising edge after the first edge that samples the strobe low (12th for the default).
- A new cycle is recognised only after IDLE has seen synced AS = 1. Back-to-back cycles need AS negation of at least 2 PI_CLK cycles.
- Word 14: reads return ID_VALUE; it is never writable.
- Word 15: IPL_n = ~reg15[2:0], updated the cycle after the write commits; bits [15:3] are plain storage.
- Words 0..13 are plain read/write storage.

Test Plan:
- Read word 14 at 0xE8001C, WAIT_CYCLES = 8 -> D_OUT = 16'h5053, D_OE = 1, DTACK_n low 12 edges after the strobe; both deassert within 3 edges of AS_n high.
- Write 16'hA55A to word 3 with only UDS, then read word 3 -> 16'hA500.
- Write 16'h0005 to word 15 -> IPL_n = 3'b010; then write 0 -> IPL_n = 3'b111.
- Write to word 14 -> BERR_n low, DTACK_n stays high; a subsequent read still returns 16'h5053.
- Access 0xE80020 (outside window) -> DTACK_n, BERR_n, D_OE never asserted.
- Negate AS_n during WAIT on a write to word 2, and separately pulse reset during ACK -> word 2 unchanged, all outputs at reset values, next access responds normally.
